cache_mem_arbiter: RTL

// - Shares the single RAM port between the icache fill path and the dcache load/store path.
// - Sits between the caches and the RAM model.
// - Registers one grant at a time and holds it until RAM reports ACCESS.
// - Default priority is data over instruction; a starvation counter bounds icache wait.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/cache_mem_arbiter_if.sv | 39 +++
 rtl/cache_mem_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: word, RAM status and arbiter grant states.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Status reported by the RAM model every cycle.
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    // Which requester currently owns the RAM port.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IGRANT = 2'b01,
        DREAD  = 2'b10,
        DWRITE = 2'b11
    } arb_state_t;

    // Default number of back-to-back data grants tolerated while the icache waits.
    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of cache-side and RAM-side signals around the memory arbiter.
// The slave modport is the arbiter's view; master is the view of the
// caches plus RAM model that surround it.
interface cache_mem_arbiter_if;
    import cpu_types_pkg::*;

    // icache side
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    // dcache side
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    // RAM side
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares the single RAM port between the icache fill path and the dcache
// load/store path. One grant is held at a time until RAM reports ACCESS.
// Data wins by default; a saturating counter forces the icache in after
// STARVE_MAX consecutive data completions while it was waiting.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                 CLK,
    input  logic                 nRST,
    cache_mem_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_t       state_q,      state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic d_req;
    logic ram_done;

    // A write takes precedence over a read when both are raised together.
    assign d_req    = bus.dREN | bus.dWEN;
    assign ram_done = (bus.ramstate == ACCESS);

    // State and starvation counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Next-state arbitration, completion, abort and counter update.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.iREN) begin
                    starve_cnt_d = '0;
                end
                if (bus.iREN && (starve_cnt_q == CNT_MAX)) begin
                    state_d = IGRANT;
                end else if (bus.dWEN) begin
                    state_d = DWRITE;
                end else if (bus.dREN) begin
                    state_d = DREAD;
                end else if (bus.iREN) begin
                    state_d = IGRANT;
                end
            end
            IGRANT: begin
                // Dropped request aborts without touching the counter.
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else if (ram_done) begin
                    state_d      = IDLE;
                    starve_cnt_d = '0;
                end
            end
            DREAD, DWRITE: begin
                if ((state_q == DREAD) ? !bus.dREN : !bus.dWEN) begin
                    state_d = IDLE;
                end else if (ram_done) begin
                    state_d = IDLE;
                    if (bus.iREN && (starve_cnt_q != CNT_MAX)) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM port and cache-side decode; wait drops only in the ACCESS cycle
    // of the requester that owns the grant.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iload    = bus.ramload;
        bus.dload    = bus.ramload;
        bus.iwait    = bus.iREN;
        bus.dwait    = d_req;
        unique case (state_q)
            IGRANT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (ram_done) begin
                    bus.iwait = 1'b0;
                end
            end
            DREAD: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.daddr;
                if (ram_done) begin
                    bus.dwait = 1'b0;
                end
            end
            DWRITE: begin
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (ram_done) begin
                    bus.dwait = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
